angular_pred_scheduler: RTL and testbench
=========================================

Name: angular_pred_scheduler

Overview:
Sequencer for the shared 4-tap angular interpolation datapath, which is built from MCM constant-multiplier blocks. For one prediction block it walks every output sample (x,y) in raster order. Per sample it derives the VVC reference index and the 5-bit fractional phase from intraPredAngle and issues one job per accepted handshake to the filter/average datapath. It sits between the mode-decision/config logic and the MCM filter array.

Parameters:
MAX_LOG2, 5, log2 of max block width/height (32)
ANGLE_W, 7, signed width of angle input
POS_W, 12, signed width of accumulated position (needs >= (MAX+1)*32)
IDX_W, 8, signed width of reference index output

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start_i  in  1  start pulse; sampled only in IDLE
angle_i  in  ANGLE_W  signed intraPredAngle; latched on accepted start
width_log2_i  in  3  log2 block width, legal 2..5
height_log2_i  in  3  log2 block height, legal 2..5
busy_o  out  1  high from accepted start until done_o cycle inclusive
done_o  out  1  one-cycle pulse after the last job is accepted
issue_valid_o  out  1  job valid to filter datapath
issue_ready_i  in  1  datapath accepts job
ref_idx_o  out  IDX_W  signed base index x+iIdx; datapath reads taps base-1..base+2 (offset by +1 ref origin downstream)
fact_o  out  5  iFact = pos[4:0]
int_only_o  out  1  fact_o==0; datapath bypasses multipliers
x_o  out  MAX_LOG2  sample column
y_o  out  MAX_LOG2  sample row
last_o  out  1  this job is (W-1,H-1)

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; all outputs 0; internal pos, x, y cleared. A reset in mid-block aborts the block; no done_o is produced.
- States: IDLE -> ROW_SETUP -> ISSUE -> (ROW_SETUP | DONE) -> IDLE.
- IDLE: if start_i, latch angle, width and height. Saturate angle to [-32,+32]. Clamp log2 sizes to [2,5]. Set pos=0, y=0. Go to ROW_SETUP.
- ROW_SETUP (1 cycle): pos <= pos + angle, i.e. pos = (y+1)*angle accumulated with no multiplier. Set x=0. Go to ISSUE.
- ISSUE: issue_valid_o=1. ref_idx = x + (pos >>> 5) (arithmetic shift, floor toward -inf). fact = pos & 31.
- On valid&&ready:
  - if x < W-1: x++ and stay in ISSUE.
  - else if y < H-1: y++ and go to ROW_SETUP.
  - else go to DONE.
- Back-pressure: while valid && !ready, all issue outputs are held stable and no state advances. Jobs are never dropped or duplicated.
- DONE: done_o=1 for exactly one cycle, issue_valid_o=0, busy_o=1; then IDLE.
- Latency: start accepted at edge T -> ROW_SETUP in cycle T+1 -> first issue_valid_o in T+2. Each row adds 1 bubble cycle. With ready held high, total = 2 + H*(W+1) cycles from start to done_o.
- start_i while busy is ignored; latched config is unchanged mid-block.
- Width rules: pos range +/-1056 fits in POS_W. ref_idx range -33..+63 fits in IDX_W signed.
- int_only_o and last_o are combinational from registered state, consistent with the other issue outputs. They are 0 when issue_valid_o=0.

Decomposition:
- Shared package angular_pkg holds:
  - state enum (IDLE, ROW_SETUP, ISSUE, DONE)
  - ANGLE_MAX=32, FRAC_BITS=5
  - POS_W/IDX_W constants
  - the job struct {ref_idx, fact, int_only, x, y, last}
- Single flat module; no sub-module. The position accumulator is too small to justify one.

Test Plan:
- angle=0, 4x4, ready=1 -> 16 jobs with ref_idx=x, fact=0, int_only=1. last_o only on (3,3). done_o at cycle 2+4*5=22 after start.
- angle=13, 8x4 -> row0: fact=13, ref_idx=x. row1: pos=26, fact=26, ref_idx=x. row2: pos=39, fact=7, ref_idx=x+1. row3: pos=52, fact=20, ref_idx=x+1.
- angle=-7, 4x4 -> row0: pos=-7, ref_idx=x-1, fact=25. row3: pos=-28, ref_idx=x-1, fact=4.
- angle=-32, 4x4 -> row y gives ref_idx=x-(y+1), fact=0, int_only=1. angle_i=+40 saturates to 32: row0 ref_idx=x+1, fact=0.
- Random ready throttling on 32x32, angle=29 -> exactly 1024 jobs in raster order, outputs stable while stalled, one done_o pulse.
- start_i pulsed mid-block with new angle -> ignored. rst_n low mid-block -> next cycle all outputs 0, no done_o. A new start then runs cleanly.

Source files
------------

// File: rtl/angular_pkg.sv
// Shared types and constants for the angular prediction sequencer.
package angular_pkg;

  localparam int unsigned MAX_LOG2  = 5;
  localparam int unsigned ANGLE_W   = 7;
  localparam int unsigned POS_W     = 12;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned FRAC_BITS = 5;
  localparam int          ANGLE_MAX = 32;

  typedef enum logic [1:0] {
    IDLE,
    ROW_SETUP,
    ISSUE,
    DONE
  } state_t;

  typedef struct packed {
    logic signed [IDX_W-1:0]  ref_idx;
    logic [FRAC_BITS-1:0]     fact;
    logic                     int_only;
    logic [MAX_LOG2-1:0]      x;
    logic [MAX_LOG2-1:0]      y;
    logic                     last;
  } job_t;

endpackage

// File: rtl/angular_pred_scheduler.sv
// Raster-order job sequencer for the shared 4-tap angular interpolation datapath:
// derives base reference index and fractional phase per output sample.
module angular_pred_scheduler
  import angular_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic signed [ANGLE_W-1:0] angle_i,
  input  logic [2:0]               width_log2_i,
  input  logic [2:0]               height_log2_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  output logic signed [IDX_W-1:0]  ref_idx_o,
  output logic [FRAC_BITS-1:0]     fact_o,
  output logic                     int_only_o,
  output logic [MAX_LOG2-1:0]      x_o,
  output logic [MAX_LOG2-1:0]      y_o,
  output logic                     last_o
);

  localparam logic signed [ANGLE_W-1:0] ANG_HI = ANGLE_W'(ANGLE_MAX);
  localparam logic signed [ANGLE_W-1:0] ANG_LO = ANGLE_W'(-ANGLE_MAX);

  state_t                     state;
  logic signed [ANGLE_W-1:0]  angle_q;
  logic [2:0]                 wl2_q;
  logic [2:0]                 hl2_q;
  logic signed [POS_W-1:0]    pos_q;
  logic [MAX_LOG2-1:0]        x_q;
  logic [MAX_LOG2-1:0]        y_q;
  logic signed [IDX_W-1:0]    ref_idx_q;
  logic [FRAC_BITS-1:0]       fact_q;
  logic                       valid_q;
  logic                       busy_q;
  logic                       done_q;

  logic signed [ANGLE_W-1:0]  angle_sat;
  logic signed [POS_W-1:0]    pos_nxt;
  logic [MAX_LOG2-1:0]        x_last;
  logic [MAX_LOG2-1:0]        y_last;
  job_t                       job_c;

  function automatic logic [2:0] clamp_log2(input logic [2:0] v);
    if (v < 3'd2)      return 3'd2;
    else if (v > 3'd5) return 3'd5;
    else               return v;
  endfunction

  always_comb begin
    angle_sat = angle_i;
    if (angle_i > ANG_HI)      angle_sat = ANG_HI;
    else if (angle_i < ANG_LO) angle_sat = ANG_LO;
  end

  // (y+1)*angle built by accumulation, one add per row
  assign pos_nxt = pos_q + POS_W'(angle_q);
  assign x_last  = MAX_LOG2'((1 << wl2_q) - 1);
  assign y_last  = MAX_LOG2'((1 << hl2_q) - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      angle_q   <= '0;
      wl2_q     <= '0;
      hl2_q     <= '0;
      pos_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      ref_idx_q <= '0;
      fact_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            angle_q <= angle_sat;
            wl2_q   <= clamp_log2(width_log2_i);
            hl2_q   <= clamp_log2(height_log2_i);
            pos_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
            state   <= ROW_SETUP;
          end
        end
        ROW_SETUP: begin
          pos_q     <= pos_nxt;
          x_q       <= '0;
          ref_idx_q <= IDX_W'(pos_nxt >>> FRAC_BITS);
          fact_q    <= pos_nxt[FRAC_BITS-1:0];
          valid_q   <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          // Everything holds while the datapath stalls
          if (valid_q && issue_ready_i) begin
            if (x_q < x_last) begin
              x_q       <= x_q + MAX_LOG2'(1);
              ref_idx_q <= ref_idx_q + IDX_W'(1);
            end else if (y_q < y_last) begin
              y_q     <= y_q + MAX_LOG2'(1);
              valid_q <= 1'b0;
              state   <= ROW_SETUP;
            end else begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    job_c          = '0;
    job_c.ref_idx  = ref_idx_q;
    job_c.fact     = fact_q;
    job_c.int_only = valid_q && (fact_q == '0);
    job_c.x        = x_q;
    job_c.y        = y_q;
    job_c.last     = valid_q && (x_q == x_last) && (y_q == y_last);
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign issue_valid_o = valid_q;
  assign ref_idx_o     = job_c.ref_idx;
  assign fact_o        = job_c.fact;
  assign int_only_o    = job_c.int_only;
  assign x_o           = job_c.x;
  assign y_o           = job_c.y;
  assign last_o        = job_c.last;

endmodule

// File: tb/tb_angular_pred_scheduler.sv
// Directed bench for angular_pred_scheduler with an expected-job scoreboard.
module tb_angular_pred_scheduler;

  logic              clk;
  logic              rst_n;
  logic              start_i;
  logic signed [6:0] angle_i;
  logic [2:0]        width_log2_i;
  logic [2:0]        height_log2_i;
  logic              busy_o;
  logic              done_o;
  logic              issue_valid_o;
  logic              issue_ready_i;
  logic signed [7:0] ref_idx_o;
  logic [4:0]        fact_o;
  logic              int_only_o;
  logic [4:0]        x_o;
  logic [4:0]        y_o;
  logic              last_o;

  typedef logic [24:0] jv_t;

  int  n_asserts;
  int  n_fail;
  jv_t exp_q[$];

  angular_pred_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .angle_i       (angle_i),
    .width_log2_i  (width_log2_i),
    .height_log2_i (height_log2_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .issue_valid_o (issue_valid_o),
    .issue_ready_i (issue_ready_i),
    .ref_idx_o     (ref_idx_o),
    .fact_o        (fact_o),
    .int_only_o    (int_only_o),
    .x_o           (x_o),
    .y_o           (y_o),
    .last_o        (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic jv_t obs_job();
    return {ref_idx_o, fact_o, int_only_o, x_o, y_o, last_o};
  endfunction

  function automatic int clamp_l2(input int v);
    if (v < 2) return 2;
    if (v > 5) return 5;
    return v;
  endfunction

  // Build expected job list from the arithmetic definition (floor division)
  task automatic push_jobs(input int angle, input int wl2, input int hl2);
    int a, w, h, pos, frac, base;
    jv_t j;
    a = (angle > 32) ? 32 : ((angle < -32) ? -32 : angle);
    w = 1 << clamp_l2(wl2);
    h = 1 << clamp_l2(hl2);
    for (int y = 0; y < h; y++) begin
      pos  = (y + 1) * a;
      frac = pos & 31;
      base = (pos - frac) / 32;
      for (int x = 0; x < w; x++) begin
        j = {8'(x + base), 5'(frac), (frac == 0), 5'(x), 5'(y),
             (x == w - 1) && (y == h - 1)};
        exp_q.push_back(j);
      end
    end
  endtask

  // throttle: random ready; inject_at: pulse a new start mid-block; abort_at: reset mid-block
  task automatic run_block(input string name, input int angle, input int wl2, input int hl2,
                           input bit throttle, input int inject_at, input int abort_at);
    int  cyc, dones, w, h;
    bit  stalled, finished;
    jv_t prev;
    w = 1 << clamp_l2(wl2);
    h = 1 << clamp_l2(hl2);
    exp_q.delete();
    push_jobs(angle, wl2, hl2);
    @(negedge clk);
    start_i       = 1'b1;
    angle_i       = 7'(angle);
    width_log2_i  = 3'(wl2);
    height_log2_i = 3'(hl2);
    issue_ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    cyc      = 2;
    dones    = 0;
    stalled  = 1'b0;
    finished = 1'b0;
    prev     = '0;
    check({name, " busy_after_start"}, 64'(busy_o), 64'd1);
    for (int k = 0; k < 8000 && !finished; k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check({name, " abort_outputs_zero"},
              64'({busy_o, done_o, issue_valid_o, obs_job()}), 64'd0);
        check({name, " abort_no_done"}, 64'(dones), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check({name, " idle_after_abort"}, 64'({done_o, busy_o, issue_valid_o}), 64'd0);
        end
        exp_q.delete();
        return;
      end
      if (k == inject_at) begin
        start_i       = 1'b1;
        angle_i       = -7'sd5;
        width_log2_i  = 3'd2;
        height_log2_i = 3'd5;
      end else begin
        start_i = 1'b0;
      end
      if (issue_valid_o) begin
        if (stalled) check({name, " stall_stable"}, 64'(obs_job()), 64'(prev));
        if (exp_q.size() == 0) check({name, " extra_job"}, 64'd1, 64'd0);
        else check({name, " job"}, 64'(obs_job()), 64'(exp_q[0]));
      end else if (int_only_o || last_o) begin
        check({name, " flags_idle"}, 64'({int_only_o, last_o}), 64'd0);
      end
      if (done_o) begin
        dones++;
        check({name, " done_remaining"}, 64'(exp_q.size()), 64'd0);
        check({name, " done_busy"}, 64'({busy_o, issue_valid_o}), 64'b10);
        if (!throttle) check({name, " done_cycle"}, 64'(cyc), 64'(2 + h * (w + 1)));
        @(negedge clk);
        start_i = 1'b0;
        check({name, " done_pulse"}, 64'({done_o, busy_o}), 64'd0);
        finished = 1'b1;
      end else begin
        issue_ready_i = throttle ? 1'($urandom_range(0, 2) != 0) : 1'b1;
        stalled = issue_valid_o && !issue_ready_i;
        prev    = obs_job();
        if (issue_valid_o && issue_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        cyc++;
      end
    end
    if (!finished) check({name, " timeout"}, 64'd1, 64'd0);
    check({name, " single_done"}, 64'(dones), 64'd1);
    issue_ready_i = 1'b0;
  endtask

  initial begin
    n_asserts     = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    start_i       = 1'b0;
    angle_i       = '0;
    width_log2_i  = 3'd2;
    height_log2_i = 3'd2;
    issue_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({busy_o, done_o, issue_valid_o, ref_idx_o, fact_o, int_only_o, x_o, y_o, last_o}),
          64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_busy", 64'({busy_o, issue_valid_o}), 64'd0);

    run_block("a0_4x4",      0,   2, 2, 1'b0, -1, -1);
    run_block("a13_8x4",     13,  3, 2, 1'b0, -1, -1);
    run_block("am7_4x4",     -7,  2, 2, 1'b0, -1, -1);
    run_block("am32_4x4",    -32, 2, 2, 1'b0, -1, -1);
    run_block("a40_sat",     40,  2, 2, 1'b0, -1, -1);
    run_block("am60_sat",    -60, 3, 2, 1'b1, -1, -1);
    run_block("clamp_l2",    9,   7, 1, 1'b0, -1, -1);
    run_block("a29_32x32",   29,  5, 5, 1'b1, -1, -1);
    run_block("inject_start", 20, 3, 3, 1'b1, 10, -1);
    run_block("abort",       10,  3, 3, 1'b0, -1, 15);
    run_block("after_abort", -20, 4, 3, 1'b0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
